// File: rtl/compressor_misr_collector.sv
// Response collector: skips the shift-register fill transient, then folds a programmed
// number of packed compressor results into a MISR and holds the final signature.
module compressor_misr_collector #(
  parameter int                 WIDTH = 32,
  parameter logic [WIDTH-1:0]   POLY  = 32'h04C11DB7,
  parameter logic [WIDTH-1:0]   SEED  = '0,
  parameter int                 SKIP  = 27,
  parameter int                 CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SKIPPING,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [WIDTH-1:0]  fold;

  assign fold = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    skip_d  = skip_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d  = num_samples;
          sig_d  = SEED;
          cnt_d  = '0;
          skip_d = '0;
          if (SKIP > 0)              state_d = SKIPPING;
          else if (num_samples == '0) state_d = DONE;
          else                        state_d = RUN;
        end
      end
      SKIPPING: begin
        skip_d = skip_q + SKIP_W'(1);
        if (skip_q == SKIP_LAST) state_d = (num_q == '0) ? DONE : RUN;
      end
      RUN: begin
        sig_d = fold;
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q never exceeds num_q - 1 here, so the increment cannot wrap
        if (cnt_d == num_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == SKIPPING) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign signature  = sig_q;
  assign sample_cnt = cnt_q;

endmodule
